// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions and exception codes.
// The ALU/decode stage and the CP0 controller both import this package.
package cp0_pkg;

    localparam logic [31:0] PRID = 32'h2022_1104;

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    // EXC_NONE uses an otherwise unassigned code so "no exception" travels in the same field.
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12,
        EXC_NONE = 5'd31
    } exc_code_t;

endpackage

// File: rtl/cp0.sv
// Coprocessor-0 exception controller in the M stage: SR/Cause/EPC/PRId registers,
// interrupt-vs-exception arbitration and the same-cycle flush/redirect request.
module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic [31:0] epc_out,
    output logic        req
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        take;

    // Interrupts win over a synchronous exception; EXL masks both.
    always_comb begin
        int_req = ((hw_int & im) != 6'd0) && ie && !exl;
        exc_req = (exc_code_in != EXC_NONE) && !exl;
        take    = int_req || exc_req;
    end

    assign req     = take && !reset;
    assign epc_out = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= hw_int;
            if (take) begin
                exl      <= 1'b1;
                exc_code <= int_req ? EXC_INT : exc_code_in;
                bd       <= bd_in;
                epc      <= bd_in ? (vpc - 32'd4) : vpc;
            end else begin
                if (en && (cp0_addr == ADDR_SR)) begin
                    im  <= cp0_in[SR_IM_HI:SR_IM_LO];
                    exl <= cp0_in[SR_EXL];
                    ie  <= cp0_in[SR_IE];
                end
                if (en && (cp0_addr == ADDR_EPC)) begin
                    epc <= cp0_in;
                end
                // Placed after the SR write so eret overrides a written EXL.
                if (exl_clr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cp0_out = '0;
        case (cp0_addr)
            ADDR_SR:    cp0_out = {16'd0, im, 8'd0, exl, ie};
            ADDR_CAUSE: cp0_out = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
            ADDR_EPC:   cp0_out = epc;
            ADDR_PRID:  cp0_out = PRID;
            default:    cp0_out = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios followed by randomized traffic,
// all compared against a word-level behavioural model of the CP0 registers.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] epc_out;
    logic        req;

    int n_vec = 0;
    int n_err = 0;

    // Model state: whole register words as software would see them.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;
    bit          m_valid = 0;

    localparam logic [4:0] C_NONE = 5'd31;
    localparam logic [4:0] C_OV   = 5'd12;
    localparam logic [4:0] C_ADEL = 5'd4;
    localparam logic [31:0] C_PRID = 32'h2022_1104;

    cp0 dut (
        .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
        .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .hw_int(hw_int), .exl_clr(exl_clr), .epc_out(epc_out), .req(req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_req();
        int pending;
        bit ints;
        bit excs;
        if (reset) return 0;
        if (m_sr & 32'h2) return 0;
        pending = int'((m_sr >> 10) & 32'h3f) & int'(hw_int);
        ints = (pending != 0) && (m_sr & 32'h1) != 0;
        excs = (exc_code_in != C_NONE);
        return ints || excs;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (int'(a))
            12: return m_sr;
            13: return m_cause;
            14: return m_epc;
            15: return C_PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        bit r;
        int pending;
        r = model_req();
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_valid = 1;
            return;
        end
        if (r) begin
            pending = int'((m_sr >> 10) & 32'h3f) & int'(hw_int);
            m_sr = m_sr | 32'h2;
            m_cause = (32'(bd_in) << 31) | (32'(hw_int) << 10) |
                      (32'((pending != 0 && (m_sr & 32'h1) != 0) ? 5'd0 : exc_code_in) << 2);
            m_epc = bd_in ? vpc - 32'd4 : vpc;
        end else begin
            m_cause = (m_cause & ~(32'h3f << 10)) | (32'(hw_int) << 10);
            if (en && cp0_addr == 5'd12) m_sr = cp0_in & 32'h0000_fc03;
            if (en && cp0_addr == 5'd14) m_epc = cp0_in;
            if (exl_clr) m_sr = m_sr & ~32'h2;
        end
    endtask

    // One clock: drive, check combinational outputs against pre-edge model, clock, update model.
    task automatic apply_stimulus(input bit rst, input bit wr, input logic [4:0] a, input logic [31:0] d,
                                  input logic [31:0] pc, input bit bd, input logic [4:0] code,
                                  input logic [5:0] hw, input bit clr);
        reset = rst; en = wr; cp0_addr = a; cp0_in = d; vpc = pc;
        bd_in = bd; exc_code_in = code; hw_int = hw; exl_clr = clr;
        #1;
        check_output("req", 32'(req), 32'(model_req()));
        if (m_valid) begin
            check_output("epc_out", epc_out, m_epc);
            check_output("cp0_out", cp0_out, model_read(a));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] a);
        apply_stimulus(0, 0, a, 0, 32'h0, 0, C_NONE, 6'd0, 0);
    endtask

    // Read a register with quiet inputs and no clock edge; compare to a fixed value.
    task automatic probe(input string tag, input logic [4:0] a, input logic [31:0] exp);
        reset = 0; en = 0; cp0_addr = a; exc_code_in = C_NONE; hw_int = 0; exl_clr = 0;
        #1;
        check_output(tag, cp0_out, exp);
    endtask

    initial begin
        logic [4:0] codes [6];
        logic [4:0] addrs [5];
        codes = '{C_NONE, C_NONE, C_OV, C_ADEL, 5'd5, 5'd10};
        addrs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd7};
        reset = 1; en = 0; cp0_addr = 0; cp0_in = 0; vpc = 0;
        bd_in = 0; exc_code_in = C_NONE; hw_int = 0; exl_clr = 0;
        @(negedge clk);

        apply_stimulus(1, 0, 12, 0, 0, 0, C_OV, 6'h3f, 0);
        apply_stimulus(1, 0, 12, 0, 0, 0, C_NONE, 0, 0);
        probe("reset_sr", 12, 0);
        probe("reset_cause", 13, 0);
        probe("reset_epc", 14, 0);
        probe("reset_prid", 15, C_PRID);

        apply_stimulus(0, 0, 13, 0, 32'h0000_3010, 0, C_OV, 0, 0);
        probe("ov_epc", 14, 32'h0000_3010);
        probe("ov_cause", 13, 32'h0000_0030);
        probe("ov_sr", 12, 32'h0000_0002);
        check_output("ov_req_after", 32'(req), 0);
        idle(12);

        apply_stimulus(0, 0, 12, 0, 0, 0, C_NONE, 0, 1);
        apply_stimulus(0, 0, 14, 0, 32'h0000_3000, 1, C_ADEL, 0, 0);
        probe("bd_epc", 14, 32'h0000_2ffc);
        probe("bd_cause", 13, 32'h8000_0010);

        apply_stimulus(0, 0, 12, 0, 0, 0, C_NONE, 0, 1);
        apply_stimulus(0, 1, 12, 32'h0000_0401, 0, 0, C_NONE, 0, 0);
        apply_stimulus(0, 0, 13, 0, 32'h0000_3040, 0, C_OV, 6'b000001, 0);
        probe("int_cause", 13, 32'h0000_0400);
        apply_stimulus(0, 0, 12, 0, 0, 0, C_NONE, 0, 1);
        apply_stimulus(0, 1, 12, 32'h0000_0400, 0, 0, C_NONE, 0, 0);
        apply_stimulus(0, 0, 13, 0, 32'h0000_3044, 0, C_OV, 6'b000001, 0);
        probe("noie_cause", 13, 32'h0000_0430);

        apply_stimulus(0, 0, 12, 0, 32'h0000_3050, 0, C_OV, 0, 0);
        apply_stimulus(0, 0, 12, 0, 0, 0, C_NONE, 0, 1);
        apply_stimulus(0, 0, 12, 0, 32'h0000_3054, 0, C_OV, 0, 0);
        probe("eret_epc", 14, 32'h0000_3054);

        apply_stimulus(0, 0, 12, 0, 0, 0, C_NONE, 0, 1);
        apply_stimulus(0, 1, 14, 32'h1234_5678, 32'h0000_3020, 0, C_OV, 0, 0);
        probe("collide_epc", 14, 32'h0000_3020);
        apply_stimulus(0, 0, 12, 0, 0, 0, C_NONE, 0, 1);
        apply_stimulus(0, 1, 13, 32'hffff_ffff, 0, 0, C_NONE, 0, 0);
        probe("cause_ro", 13, 32'h0000_0030);

        apply_stimulus(0, 0, 12, 0, 32'h0000_4000, 0, C_OV, 0, 0);
        apply_stimulus(1, 1, 12, 32'hffff_ffff, 32'h0000_5000, 0, C_OV, 6'h3f, 0);
        probe("rst_sr", 12, 0);
        probe("rst_cause", 13, 0);
        probe("rst_epc", 14, 0);
        probe("rst_prid", 15, C_PRID);
        probe("rst_unmapped", 7, 0);

        for (int i = 0; i < 400; i++) begin
            bit rst_r;
            logic [5:0] hw_r;
            rst_r = ($urandom_range(0, 63) == 0);
            hw_r  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            apply_stimulus(rst_r, ($urandom_range(0, 3) == 0), addrs[$urandom_range(0, 4)], $urandom,
                           {$urandom_range(0, 65535), 2'b00}, 1'($urandom), codes[$urandom_range(0, 5)],
                           hw_r, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception controller sitting in the M stage, directly downstream of the E-stage ALU whose `e_code` it consumes after one pipeline register. It holds the SR, Cause, EPC and PRId registers, arbitrates hardware interrupts against synchronous exceptions, and raises a same-cycle request that flushes the pipeline and redirects fetch to the handler. It also services `mtc0`/`mfc0` accesses and clears the exception level on `eret`.

## Interface
- `PRID`, 32'h2022_1104, constant value returned for register 15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all CP0 state.
- `en`  in  1  `mtc0` write strobe from the M stage.
- `cp0_addr`  in  5  register number for read and write (12 SR, 13 Cause, 14 EPC, 15 PRId).
- `cp0_in`  in  32  `mtc0` write data.
- `cp0_out`  out  32  `mfc0` read data, combinational.
- `vpc`  in  32  PC of the M-stage instruction.
- `bd_in`  in  1  M-stage instruction is in a branch delay slot.
- `exc_code_in`  in  5  pipelined ALU/decode exception code; `exc_none` means no exception.
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `exl_clr`  in  1  `eret` in the M stage.
- `epc_out`  out  32  current EPC register value.
- `req`  out  1  exception or interrupt taken this cycle, combinational.

## Operation
- **SR**: IM = [15:10], EXL = [1], IE = [0]. All other bits read 0.
- **Cause**: BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits read 0.
- **Interrupt request**: `int_req = |(hw_int & IM) & IE & ~EXL`.
- **Exception request**: `exc_req = (exc_code_in != exc_none) & ~EXL`.
- **Combined request**: `req = int_req | exc_req`. An interrupt has priority over an exception in the same cycle.
- **On `req` (clock edge)**:
  - EXL <= 1.
  - ExcCode <= `exc_int` (0) if `int_req`, else `exc_code_in`.
  - BD <= `bd_in`.
  - EPC <= `bd_in` ? `vpc - 4` : `vpc`, with 32-bit wrap-around.
- **IP**: loaded from `hw_int` every cycle, regardless of other activity.
- **`mtc0` (`en`, no `req`)**:
  - Address 12 writes IM, EXL and IE only.
  - Address 14 writes all 32 bits of EPC.
  - Addresses 13, 15 and all others are ignored.
- **`eret` (`exl_clr`, no `req`)**: EXL <= 0.
- **Simultaneous events**:
  - `req` discards a concurrent `mtc0` and a concurrent `exl_clr`.
  - `mtc0` to SR together with `exl_clr` (no `req`): the written EXL is applied first, then `exl_clr` forces EXL to 0.
- **Read path**: `cp0_out` returns the selected register; PRId returns `PRID`; unmapped addresses return 0. Reads show pre-edge state, with no write-through bypass.
- **Nested events**: while EXL = 1, all new interrupts and exceptions are masked and `req` stays 0.

## Timing
- **Reset values**: SR, Cause and EPC are 0; `req` = 0; `epc_out` = 0; `cp0_out` = 0 for addresses 12–14 and `PRID` for address 15.
- **`req`**: combinational from the current inputs and register state, valid in the same cycle. The pipeline flushes on that same edge.
- **Register updates**: all take effect on the rising edge after the triggering cycle.
- **`epc_out`**: shows the new EPC one cycle after `req`.
- **`hw_int` to IP**: one cycle.
- **Reset during any activity**: state is fully cleared on that edge, and `req` is suppressed in the reset cycle.

## Structure
- Register numbers, SR and Cause bit positions, and the `exc_*` codes (Int=0, AdEL=4, AdES=5, RI=10, Ov=12, plus `exc_none`) belong in the shared `macros.v`, next to the existing ALU exception codes.
- Single flat module with no sub-modules. The request/priority logic is one combinational block; the register file is one sequential block.

## Test plan
- **Overflow exception**: reset; `vpc`=32'h0000_3010, `exc_code_in`=Ov, `bd_in`=0 -> `req`=1 the same cycle. Next cycle: EPC=32'h0000_3010, ExcCode=12, EXL=1, `req`=0.
- **Exception in delay slot**: `bd_in`=1, `vpc`=32'h0000_3000, `exc_code_in`=AdEL -> EPC=32'h0000_2FFC, Cause[31]=1, ExcCode=4.
- **Interrupt priority**: `mtc0` SR=32'h0000_0401; then `hw_int`=6'b000001 together with `exc_code_in`=Ov -> `req`=1 and ExcCode=0. With IE=0 the same stimulus gives ExcCode=12.
- **Masking and `eret`**: while EXL=1, an Ov exception gives `req`=0. Then `exl_clr`=1 -> EXL=0 next cycle, and the same Ov now raises `req`.
- **Access collisions**: `mtc0` EPC=32'h1234_5678 in the same cycle as an exception at `vpc`=32'h0000_3020 -> EPC=32'h0000_3020. `mtc0` to Cause leaves Cause unchanged.
- **Reset mid-operation**: with EXL=1 and EPC nonzero, pulse `reset` -> SR, Cause and EPC all 0. Reading address 15 gives 32'h2022_1104; reading address 7 gives 0.
